bin_count_src: RTL and testbench
================================

Name: bin_count_src

Overview:
- Sequential binary-code source feeding the binary-to-gray converter stage.
- Generates a stepped WIDTH-bit binary count with a valid/ready handshake, so the downstream converter sees each code exactly once.
- Supports up/down counting, synchronous load, wrap or one-shot modes, and a terminal-count pulse.
- Optionally also emits the registered Gray equivalent, used for self-check.

Parameters:
- WIDTH, 4, count width in bits; bin_out[WIDTH-1:0] maps MSB..LSB to converter inputs b3..b0.
- WRAP, 1, 1 = count wraps at the terminal value; 0 = stop in DONE after the terminal transfer.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin/resume counting (IDLE or DONE -> RUN).
- stop  input  1  halt counting (RUN -> IDLE).
- up_dn  input  1  1 = increment, 0 = decrement; sampled on each transfer.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- out_ready  input  1  downstream accepts bin_out this cycle.
- out_valid  output  1  bin_out holds a valid code.
- bin_out  output  WIDTH  current binary code, registered.
- tc  output  1  one-cycle pulse when the terminal code is transferred.
- busy  output  1  high when state is RUN.

Behaviour:
- Reset (async assert, sync release), all registered:
  - state = IDLE, count = 0.
  - out_valid = 0, bin_out = 0, tc = 0, busy = 0.
  - gray_out = 0 if compiled in.
- Outputs:
  - bin_out = count.
  - out_valid = (state == RUN).
  - busy = (state == RUN).
- A transfer occurs when out_valid && out_ready.
- IDLE:
  - count held, out_valid = 0.
  - start = 1 -> RUN next cycle; first presented code is the held count.
- RUN:
  - out_valid = 1.
  - On transfer, count <= count + 1 if up_dn, else count - 1, modulo 2^WIDTH. No saturation.
  - Without a transfer, bin_out is held stable (standard valid/ready: no change while valid && !ready).
- Terminal code is all-ones when up_dn = 1 and 0 when up_dn = 0, evaluated at transfer time.
  - On transfer of the terminal code: tc = 1 for exactly the next cycle.
  - WRAP = 1: count wraps (15 -> 0 up, 0 -> 15 down); stay in RUN.
  - WRAP = 0: go to DONE; count stays at the terminal value; out_valid = 0.
- DONE:
  - out_valid = 0, count held.
  - start = 1 -> RUN with count reset to 0 (up_dn = 1) or all-ones (up_dn = 0).
- stop = 1 in RUN -> IDLE next cycle.
  - A transfer in the same cycle still completes: count advances and tc fires if terminal.
  - stop has priority over start in the same cycle.
- load = 1 (any state):
  - count <= load_val next cycle; state unchanged.
  - Takes priority over advance, start-reset and tc; no tc is generated.
  - If a transfer coincides with load, the transfer counts as accepted, but the next code is load_val, not count ± 1.
- start in RUN, or stop in IDLE/DONE: ignored.
- up_dn changes take effect only at the next transfer; the held code is never altered.
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronous); no tc is emitted.

Optional Feature:
- Macro: BIN_COUNT_SRC_GRAY_OUT_EN.
- Defined:
  - Extra port gray_out, output, WIDTH bits.
  - Registered value = next_count ^ (next_count >> 1), so it is cycle-aligned with bin_out (gray_out == bin_out ^ (bin_out >> 1) every cycle).
  - Reset value 0.
- Undefined:
  - Port and logic absent; all other behaviour identical.

Test Plan:
- Reset, start, up_dn = 1, out_ready = 1, WRAP = 1 -> bin_out 0,1,2,…,15,0 on consecutive cycles; tc high only the cycle after 15 transfers; out_valid continuously 1.
- Backpressure: in RUN at bin_out = 5, out_ready = 0 for 3 cycles -> bin_out stays 5, out_valid 1; out_ready = 1 -> next cycle bin_out = 6.
- WRAP = 0, up_dn = 0, load_val = 2 loaded, start -> codes 2,1,0; tc pulses after 0 transfers; state DONE; out_valid 0, bin_out 0. Second start -> RUN at 15.
- Load during transfer: bin_out = 9, out_ready = 1, load = 1, load_val = 3 -> next bin_out = 3, no tc. Load with load_val = 15 then a transfer -> tc.
- stop with transfer at bin_out = 7 -> next cycle IDLE, out_valid 0, count 8. Start -> presents 8. Assert rst_n = 0 mid-RUN -> bin_out and out_valid 0 immediately.
- With BIN_COUNT_SRC_GRAY_OUT_EN: full up-count 0..15 -> gray_out 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, aligned with bin_out every cycle.

Source files
------------

// File: rtl/bin_count_src.sv
// Stepped binary count source with valid/ready handshake, load, wrap/one-shot and terminal pulse.
// Define BIN_COUNT_SRC_GRAY_OUT_EN to add a registered gray_out aligned with bin_out.
module bin_count_src #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             busy
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_out
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] Ones = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_d;
  logic             xfer, is_term;

  assign xfer    = (state_q == StRun) && out_ready;
  assign is_term = (count_q == (up_dn ? Ones : '0));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (xfer) begin
          count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
          if (is_term) begin
            tc_d = 1'b1;
            if (!WRAP) begin
              // One-shot: park on the terminal code.
              count_d = count_q;
              state_d = StDone;
            end
          end
        end
        if (stop) state_d = StIdle;
      end
      StDone: begin
        if (start && !stop) begin
          state_d = StRun;
          count_d = up_dn ? '0 : Ones;
        end
      end
      default: state_d = StIdle;
    endcase
    // Load overrides any advance, restart value and terminal pulse.
    if (load) begin
      count_d = load_val;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      out_valid <= 1'b0;
      tc        <= 1'b0;
      busy      <= 1'b0;
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
      gray_out  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      out_valid <= (state_d == StRun);
      tc        <= tc_d;
      busy      <= (state_d == StRun);
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
      gray_out  <= count_d ^ (count_d >> 1);
`endif
    end
  end

  assign bin_out = count_q;

endmodule

// File: tb/tb_bin_count_src.sv
// Directed bench for bin_count_src: a wrapping instance and a one-shot instance share stimulus.
module tb_bin_count_src;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, up_dn, load, out_ready;
  logic [3:0] load_val;

  logic       w_valid, w_tc, w_busy;
  logic [3:0] w_bin;
  logic       o_valid, o_tc, o_busy;
  logic [3:0] o_bin;
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
  logic [3:0] w_gray, o_gray;
  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_count_src #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up_dn(up_dn), .load(load),
    .load_val(load_val), .out_ready(out_ready), .out_valid(w_valid), .bin_out(w_bin),
    .tc(w_tc), .busy(w_busy)
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
    , .gray_out(w_gray)
`endif
  );

  bin_count_src #(.WIDTH(4), .WRAP(1'b0)) u_once (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up_dn(up_dn), .load(load),
    .load_val(load_val), .out_ready(out_ready), .out_valid(o_valid), .bin_out(o_bin),
    .tc(o_tc), .busy(o_busy)
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
    , .gray_out(o_gray)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; up_dn = 1; load = 0; load_val = 0; out_ready = 1;
    #8;
    check("rst_bin", w_bin, 0);
    check("rst_valid", w_valid, 0);
    check("rst_tc", w_tc, 0);
    check("rst_busy", w_busy, 0);
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
    check("rst_gray", w_gray, 0);
`endif
    #4 rst_n = 1'b1;

    // Full wrapping up-count.
    start = 1; step(); start = 0;
    check("start_bin", w_bin, 0);
    check("start_valid", w_valid, 1);
    check("start_busy", w_busy, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("up_bin", w_bin, (i + 1) % 16);
      check("up_tc", w_tc, (i == 15) ? 1 : 0);
      check("up_valid", w_valid, 1);
`ifdef BIN_COUNT_SRC_GRAY_OUT_EN
      check("up_gray", w_gray, gray_tab[(i + 1) % 16]);
`endif
    end

    // Backpressure at 5.
    repeat (5) step();
    check("bp_pre", w_bin, 5);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", w_bin, 5);
      check("bp_valid", w_valid, 1);
    end
    out_ready = 1; step();
    check("bp_release", w_bin, 6);

    // Load coinciding with a transfer.
    repeat (3) step();
    check("ld_pre", w_bin, 9);
    load = 1; load_val = 3; step();
    check("ld_bin", w_bin, 3);
    check("ld_tc", w_tc, 0);
    load_val = 15; step();
    check("ld15_bin", w_bin, 15);
    check("ld15_tc", w_tc, 0);
    load = 0; step();
    check("ld15_wrap", w_bin, 0);
    check("ld15_tcpulse", w_tc, 1);

    // Stop together with a transfer at 7.
    repeat (7) step();
    check("stop_pre", w_bin, 7);
    stop = 1; step(); stop = 0;
    check("stop_bin", w_bin, 8);
    check("stop_valid", w_valid, 0);
    check("stop_busy", w_busy, 0);
    step();
    check("idle_hold", w_bin, 8);
    start = 1; step(); start = 0;
    check("resume_bin", w_bin, 8);
    check("resume_valid", w_valid, 1);
    step();
    check("resume_adv", w_bin, 9);

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    check("arst_bin", w_bin, 0);
    check("arst_valid", w_valid, 0);
    check("arst_busy", w_busy, 0);
    check("arst_tc", w_tc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One-shot down-count from 2.
    up_dn = 0; load = 1; load_val = 2; step(); load = 0;
    check("os_load", o_bin, 2);
    check("os_idle_valid", o_valid, 0);
    start = 1; step(); start = 0;
    check("os_c2", o_bin, 2);
    check("os_valid", o_valid, 1);
    step();
    check("os_c1", o_bin, 1);
    step();
    check("os_c0", o_bin, 0);
    check("os_c0_tc", o_tc, 0);
    step();
    check("os_done_tc", o_tc, 1);
    check("os_done_valid", o_valid, 0);
    check("os_done_busy", o_busy, 0);
    check("os_done_bin", o_bin, 0);
    step();
    check("os_tc_once", o_tc, 0);
    check("os_done_hold", o_bin, 0);
    start = 1; step(); start = 0;
    check("os_restart_bin", o_bin, 15);
    check("os_restart_valid", o_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
